// File: rtl/if_id_buffer_pkg.sv
// Shared constants for the IF/ID instruction buffer: field widths, control-bus
// bit positions and the compressed-instruction test.
package if_id_buffer_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;

  localparam int STALL_IF_BIT     = 0;
  localparam int STALL_ID_BIT     = 1;
  localparam int FLUSH_IFID_BIT   = 0;
  localparam int ISSUE_SINGLE_BIT = 0;

  // Decode slot occupancy, named for readability of the pop logic.
  typedef enum logic [1:0] {
    SLOTS_NONE = 2'b00,
    SLOTS_ONE  = 2'b01,
    SLOTS_TWO  = 2'b11
  } slotMask_e;

  // Any encoding whose low two bits are not 2'b11 is a 16-bit instruction.
  function automatic logic isCompressed(input logic [INST_WIDTH-1:0] inst);
    return inst[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch-side and decode-side bus of the IF/ID buffer; master is the
// fetch/decode environment, slave is the buffer.
interface if_id_buffer_if
  import if_id_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = if_id_buffer_pkg::ADDR_WIDTH
);
  // Handshake: a fetch pair is accepted on a rising clk edge when Fetch_Ready=1
  // and Fetch_Valid[0]=1 (Fetch_Valid[1] only adds slot1); Fetch_Ready depends
  // on registered state only. Decode_Valid marks live slots; there is no
  // decode-side ready, the consumer pops via stall/issue controls instead.
  logic [1:0]            Fetch_Valid;
  logic [ADDR_WIDTH-1:0] Fetch_PC0;
  logic [ADDR_WIDTH-1:0] Fetch_PC1;
  logic [INST_WIDTH-1:0] Fetch_Inst0;
  logic [INST_WIDTH-1:0] Fetch_Inst1;
  logic                  Fetch_Ready;

  logic [1:0]            Decode_Valid;
  logic [ADDR_WIDTH-1:0] Decode_PC0;
  logic [ADDR_WIDTH-1:0] Decode_PC1;
  logic [INST_WIDTH-1:0] Decode_Inst0;
  logic [INST_WIDTH-1:0] Decode_Inst1;
  logic                  Decode_16BitFlag_0;
  logic                  Decode_16BitFlag_1;

  modport master (
    output Fetch_Valid, Fetch_PC0, Fetch_PC1, Fetch_Inst0, Fetch_Inst1,
    input  Fetch_Ready,
    input  Decode_Valid, Decode_PC0, Decode_PC1, Decode_Inst0, Decode_Inst1,
    input  Decode_16BitFlag_0, Decode_16BitFlag_1
  );

  modport slave (
    input  Fetch_Valid, Fetch_PC0, Fetch_PC1, Fetch_Inst0, Fetch_Inst1,
    output Fetch_Ready,
    output Decode_Valid, Decode_PC0, Decode_PC1, Decode_Inst0, Decode_Inst1,
    output Decode_16BitFlag_0, Decode_16BitFlag_1
  );

endinterface

// File: rtl/if_id_buffer_fifo_mem.sv
// Entry storage for the IF/ID buffer: two write ports, two asynchronous read
// ports, no reset on the array (validity lives in the occupancy count).
module ifid_fifo_mem
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ADDR_WIDTH + INST_WIDTH
) (
  input  logic                     clk,
  input  logic                     we0,
  input  logic [$clog2(DEPTH)-1:0] wa0,
  input  logic [WIDTH-1:0]         wd0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] wa1,
  input  logic [WIDTH-1:0]         wd1,
  input  logic [$clog2(DEPTH)-1:0] ra0,
  input  logic [$clog2(DEPTH)-1:0] ra1,
  output logic [WIDTH-1:0]         rd0,
  output logic [WIDTH-1:0]         rd1
);

  logic [WIDTH-1:0] mem [DEPTH];

  // wa0 and wa1 are always consecutive slots, so the ports never collide.
  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/if_id_buffer.sv
// Dual-issue IF/ID circular instruction buffer. Define IFID_PERF_CNT_EN to
// enable the ID-stall and flush performance counters (tied to zero otherwise).
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = if_id_buffer_pkg::ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  if_id_buffer_if.slave          bus,
  input  logic [4:0]             Ctrl_Stall,
  input  logic [3:0]             Flush,
  input  logic [3:0]             issue_select,
  output logic [31:0]            Perf_IdStallCnt,
  output logic [31:0]            Perf_FlushCnt,
  output logic [$clog2(DEPTH):0] dbgCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + INST_WIDTH;

  logic [PW-1:0] headPtr, tailPtr, headPlus1, tailPlus1;
  logic [CW-1:0] count, freeCnt, pushCnt, popCnt;
  logic          flushNow, stallIf, stallId, singleIssue;
  logic          pushEn, pushTwo;
  logic [1:0]    decValid;
  logic [EW-1:0] rdData0, rdData1;
  logic          unusedBits;

  assign flushNow    = Flush[FLUSH_IFID_BIT];
  assign stallIf     = Ctrl_Stall[STALL_IF_BIT];
  assign stallId     = Ctrl_Stall[STALL_ID_BIT];
  assign singleIssue = issue_select[ISSUE_SINGLE_BIT];
  assign unusedBits  = ^{Ctrl_Stall[4:2], Flush[3:1], issue_select[3:1]};

  assign headPlus1 = headPtr + PW'(1);
  assign tailPlus1 = tailPtr + PW'(1);

  // Ready needs room for a full pair, so a granted push can never overflow.
  assign freeCnt         = CW'(DEPTH) - count;
  assign bus.Fetch_Ready = freeCnt >= CW'(2);

  assign pushEn  = bus.Fetch_Ready & ~stallIf & bus.Fetch_Valid[0] & ~flushNow;
  assign pushTwo = pushEn & bus.Fetch_Valid[1];

  always_comb begin
    pushCnt = '0;
    popCnt  = '0;
    if (pushEn) pushCnt = pushTwo ? CW'(2) : CW'(1);
    if (!(stallId || flushNow)) begin
      if (singleIssue) popCnt = (count >= CW'(1)) ? CW'(1) : '0;
      else             popCnt = (count >= CW'(2)) ? CW'(2) : count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flushNow) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      headPtr <= headPtr + popCnt[PW-1:0];
      tailPtr <= tailPtr + pushCnt[PW-1:0];
      count   <= count + pushCnt - popCnt;
    end
  end

  ifid_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) uMem (
    .clk (clk),
    .we0 (pushEn),
    .wa0 (tailPtr),
    .wd0 ({bus.Fetch_PC0, bus.Fetch_Inst0}),
    .we1 (pushTwo),
    .wa1 (tailPlus1),
    .wd1 ({bus.Fetch_PC1, bus.Fetch_Inst1}),
    .ra0 (headPtr),
    .ra1 (headPlus1),
    .rd0 (rdData0),
    .rd1 (rdData1)
  );

  always_comb begin
    decValid = SLOTS_NONE;
    if (!flushNow) begin
      if (count >= CW'(2))      decValid = SLOTS_TWO;
      else if (count >= CW'(1)) decValid = SLOTS_ONE;
    end
  end

  // Dead slots read as zero so stale array contents never reach decode.
  assign bus.Decode_Valid       = decValid;
  assign bus.Decode_PC0         = decValid[0] ? rdData0[EW-1 -: ADDR_WIDTH] : '0;
  assign bus.Decode_Inst0       = decValid[0] ? rdData0[INST_WIDTH-1:0] : '0;
  assign bus.Decode_16BitFlag_0 = decValid[0] & isCompressed(rdData0[INST_WIDTH-1:0]);
  assign bus.Decode_PC1         = decValid[1] ? rdData1[EW-1 -: ADDR_WIDTH] : '0;
  assign bus.Decode_Inst1       = decValid[1] ? rdData1[INST_WIDTH-1:0] : '0;
  assign bus.Decode_16BitFlag_1 = decValid[1] & isCompressed(rdData1[INST_WIDTH-1:0]);

  assign dbgCount = count;

`ifdef IFID_PERF_CNT_EN
  logic [31:0] idStallCnt, flushCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      idStallCnt <= '0;
      flushCnt   <= '0;
    end else begin
      if (stallId && (decValid != SLOTS_NONE)) idStallCnt <= idStallCnt + 32'd1;
      if (flushNow)                            flushCnt   <= flushCnt + 32'd1;
    end
  end

  assign Perf_IdStallCnt = idStallCnt;
  assign Perf_FlushCnt   = flushCnt;
`else
  assign Perf_IdStallCnt = 32'h0;
  assign Perf_FlushCnt   = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed vector table, hand-written corner sequences
// and random traffic, all checked against a queue-based occupancy model.
module tb_if_id_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ctrlStall;
  logic [3:0]  flush;
  logic [3:0]  issueSel;
  logic [31:0] perfIdStall, perfFlush;
  logic [2:0]  dbgCount;

  always #5 clk = ~clk;

  if_id_buffer_if #(.ADDR_WIDTH(AW)) bus ();

  if_id_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .Ctrl_Stall      (ctrlStall),
    .Flush           (flush),
    .issue_select    (issueSel),
    .Perf_IdStallCnt (perfIdStall),
    .Perf_FlushCnt   (perfFlush),
    .dbgCount        (dbgCount)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  fv;
    logic [31:0] pc0, pc1, inst0, inst1;
    logic [4:0]  stall;
    logic [3:0]  flush;
    logic [3:0]  issue;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [1:0]  expDv;
    logic [31:0] expPc0;
    logic [2:0]  expCnt;
    logic        expRdy;
    logic [1:0]  expFlags;
  } vec_t;

  // Reference model: ordered queue of {pc, inst} entries plus counters.
  logic [63:0] exp_q[$];
  logic [31:0] mStallCnt, mFlushCnt;
  int nVec = 0;
  int nMis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic [1:0] fv, input logic [31:0] pc0, input logic [31:0] pc1,
                               input logic [31:0] i0, input logic [31:0] i1, input logic [4:0] st,
                               input logic [3:0] fl, input logic [3:0] iss);
    stim_t s;
    s.rst = 1'b0; s.fv = fv; s.pc0 = pc0; s.pc1 = pc1; s.inst0 = i0; s.inst1 = i1;
    s.stall = st; s.flush = fl; s.issue = iss;
    return s;
  endfunction

  function automatic vec_t mv(input stim_t s, input logic [1:0] dv, input logic [31:0] pc0,
                              input logic [2:0] cnt, input logic rdy, input logic [1:0] flags);
    vec_t v;
    v.s = s; v.expDv = dv; v.expPc0 = pc0; v.expCnt = cnt; v.expRdy = rdy; v.expFlags = flags;
    return v;
  endfunction

  task automatic drive(input stim_t s);
    rst             = s.rst;
    bus.Fetch_Valid = s.fv;
    bus.Fetch_PC0   = s.pc0;
    bus.Fetch_PC1   = s.pc1;
    bus.Fetch_Inst0 = s.inst0;
    bus.Fetch_Inst1 = s.inst1;
    ctrlStall       = s.stall;
    flush           = s.flush;
    issueSel        = s.issue;
  endtask

  function automatic logic [1:0] modelValid(input stim_t s);
    int n;
    n = exp_q.size();
    return s.flush[0] ? 2'b00 : {n >= 2, n >= 1};
  endfunction

  task automatic checkModel(input stim_t s);
    int          n;
    logic [1:0]  dv;
    logic [63:0] e0, e1;
    logic [31:0] expStall, expFlush;
    n  = exp_q.size();
    dv = modelValid(s);
    e0 = dv[0] ? exp_q[0] : 64'h0;
    e1 = dv[1] ? exp_q[1] : 64'h0;
`ifdef IFID_PERF_CNT_EN
    expStall = mStallCnt;
    expFlush = mFlushCnt;
`else
    expStall = 32'h0;
    expFlush = 32'h0;
`endif
    check("m_valid", 64'(bus.Decode_Valid), 64'(dv));
    check("m_pc0",   64'(bus.Decode_PC0), 64'(e0[63:32]));
    check("m_inst0", 64'(bus.Decode_Inst0), 64'(e0[31:0]));
    check("m_flag0", 64'(bus.Decode_16BitFlag_0), 64'(dv[0] && e0[1:0] != 2'b11));
    check("m_pc1",   64'(bus.Decode_PC1), 64'(e1[63:32]));
    check("m_inst1", 64'(bus.Decode_Inst1), 64'(e1[31:0]));
    check("m_flag1", 64'(bus.Decode_16BitFlag_1), 64'(dv[1] && e1[1:0] != 2'b11));
    check("m_ready", 64'(bus.Fetch_Ready), 64'((DEPTH - n) >= 2));
    check("m_count", 64'(dbgCount), 64'(n));
    check("m_perf_stall", 64'(perfIdStall), 64'(expStall));
    check("m_perf_flush", 64'(perfFlush), 64'(expFlush));
  endtask

  task automatic tick(input stim_t s);
    int         n, pops;
    logic [1:0] dv;
    logic       rdy;
    n   = exp_q.size();
    dv  = modelValid(s);
    rdy = (DEPTH - n) >= 2;
    @(posedge clk);
    if (s.rst) begin
      exp_q.delete();
      mStallCnt = '0;
      mFlushCnt = '0;
    end else begin
      if (s.stall[1] && dv != 2'b00) mStallCnt = mStallCnt + 32'd1;
      if (s.flush[0])                mFlushCnt = mFlushCnt + 32'd1;
      if (s.flush[0]) begin
        exp_q.delete();
      end else begin
        if (s.stall[1])     pops = 0;
        else if (s.issue[0]) pops = (n < 1) ? n : 1;
        else                 pops = (n < 2) ? n : 2;
        repeat (pops) void'(exp_q.pop_front());
        if (rdy && !s.stall[0] && s.fv[0]) begin
          exp_q.push_back({s.pc0, s.inst0});
          if (s.fv[1]) exp_q.push_back({s.pc1, s.inst1});
        end
      end
    end
    #1;
  endtask

  task automatic step(input stim_t s);
    drive(s);
    #1;
    checkModel(s);
    tick(s);
  endtask

  vec_t  tbl[27];
  stim_t idle, s;
  logic [31:0] expPerf;

  initial begin
    idle = mk(2'b00, 0, 0, 0, 0, 5'b0, 4'b0, 4'b0);
    tbl[0]  = mv(idle,                                               2'b00, 32'h0,   3'd0, 1'b1, 2'b00);
    tbl[1]  = mv(mk(2'b11, 32'h100, 32'h104, NOP, NOP, 0, 0, 0),     2'b00, 32'h0,   3'd0, 1'b1, 2'b00);
    tbl[2]  = mv(idle,                                               2'b11, 32'h100, 3'd2, 1'b1, 2'b00);
    tbl[3]  = mv(idle,                                               2'b00, 32'h0,   3'd0, 1'b1, 2'b00);
    tbl[4]  = mv(mk(2'b11, 32'h100, 32'h104, NOP, NOP, 2, 0, 0),     2'b00, 32'h0,   3'd0, 1'b1, 2'b00);
    tbl[5]  = mv(mk(2'b00, 0, 0, 0, 0, 0, 0, 1),                     2'b11, 32'h100, 3'd2, 1'b1, 2'b00);
    tbl[6]  = mv(mk(2'b00, 0, 0, 0, 0, 2, 0, 0),                     2'b01, 32'h104, 3'd1, 1'b1, 2'b00);
    tbl[7]  = mv(idle,                                               2'b01, 32'h104, 3'd1, 1'b1, 2'b00);
    tbl[8]  = mv(mk(2'b11, 32'h200, 32'h204, NOP, NOP, 2, 0, 0),     2'b00, 32'h0,   3'd0, 1'b1, 2'b00);
    tbl[9]  = mv(mk(2'b11, 32'h208, 32'h20C, NOP, NOP, 2, 0, 0),     2'b11, 32'h200, 3'd2, 1'b1, 2'b00);
    tbl[10] = mv(mk(2'b11, 32'h210, 32'h214, NOP, NOP, 2, 0, 0),     2'b11, 32'h200, 3'd4, 1'b0, 2'b00);
    tbl[11] = mv(mk(2'b00, 0, 0, 0, 0, 2, 0, 0),                     2'b11, 32'h200, 3'd4, 1'b0, 2'b00);
    tbl[12] = mv(idle,                                               2'b11, 32'h200, 3'd4, 1'b0, 2'b00);
    tbl[13] = mv(mk(2'b11, 32'h300, 32'h304, NOP, NOP, 0, 0, 0),     2'b11, 32'h208, 3'd2, 1'b1, 2'b00);
    tbl[14] = mv(mk(2'b11, 32'h308, 32'h30C, NOP, NOP, 0, 0, 0),     2'b11, 32'h300, 3'd2, 1'b1, 2'b00);
    tbl[15] = mv(mk(2'b01, 32'h310, 32'h0, NOP, NOP, 0, 0, 0),       2'b11, 32'h308, 3'd2, 1'b1, 2'b00);
    tbl[16] = mv(mk(2'b11, 32'h314, 32'h318, NOP, NOP, 0, 0, 0),     2'b01, 32'h310, 3'd1, 1'b1, 2'b00);
    tbl[17] = mv(mk(2'b11, 32'h31C, 32'h320, NOP, NOP, 0, 0, 0),     2'b11, 32'h314, 3'd2, 1'b1, 2'b00);
    tbl[18] = mv(mk(2'b10, 32'h999, 32'h99C, NOP, NOP, 0, 0, 0),     2'b11, 32'h31C, 3'd2, 1'b1, 2'b00);
    tbl[19] = mv(idle,                                               2'b00, 32'h0,   3'd0, 1'b1, 2'b00);
    tbl[20] = mv(mk(2'b11, 32'h400, 32'h404, NOP, NOP, 2, 0, 0),     2'b00, 32'h0,   3'd0, 1'b1, 2'b00);
    tbl[21] = mv(mk(2'b01, 32'h408, 32'h0, NOP, NOP, 2, 0, 0),       2'b11, 32'h400, 3'd2, 1'b1, 2'b00);
    tbl[22] = mv(mk(2'b11, 32'h40C, 32'h410, NOP, NOP, 2, 1, 0),     2'b00, 32'h0,   3'd3, 1'b0, 2'b00);
    tbl[23] = mv(idle,                                               2'b00, 32'h0,   3'd0, 1'b1, 2'b00);
    tbl[24] = mv(mk(2'b11, 32'h500, 32'h502, 32'h4501, NOP, 2, 0, 0), 2'b00, 32'h0,  3'd0, 1'b1, 2'b00);
    tbl[25] = mv(mk(2'b00, 0, 0, 0, 0, 2, 0, 0),                     2'b11, 32'h500, 3'd2, 1'b1, 2'b01);
    tbl[26] = mv(mk(2'b00, 0, 0, 0, 0, 0, 1, 0),                     2'b00, 32'h0,   3'd2, 1'b1, 2'b00);

    // Power-up reset: DUT state is unknown before it, so no checks here.
    s = idle;
    s.rst = 1'b1;
    drive(s);
    @(posedge clk);
    @(posedge clk);
    #1;
    exp_q.delete();
    mStallCnt = '0;
    mFlushCnt = '0;

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].s);
      #1;
      checkModel(tbl[i].s);
      check($sformatf("t%0d_valid", i), 64'(bus.Decode_Valid), 64'(tbl[i].expDv));
      check($sformatf("t%0d_pc0", i),   64'(bus.Decode_PC0), 64'(tbl[i].expPc0));
      check($sformatf("t%0d_count", i), 64'(dbgCount), 64'(tbl[i].expCnt));
      check($sformatf("t%0d_ready", i), 64'(bus.Fetch_Ready), 64'(tbl[i].expRdy));
      check($sformatf("t%0d_flags", i),
            64'({bus.Decode_16BitFlag_1, bus.Decode_16BitFlag_0}), 64'(tbl[i].expFlags));
      tick(tbl[i].s);
    end

    // Continuous pair pushes with dual issue: order must survive pointer wrap.
    for (int k = 0; k < 8; k++) begin
      s = mk(2'b11, 32'h700 + 32'(8 * k), 32'h704 + 32'(8 * k), NOP, NOP, 0, 0, 0);
      drive(s);
      #1;
      checkModel(s);
      if (k > 0) begin
        check($sformatf("wrap%0d_pc0", k), 64'(bus.Decode_PC0), 64'(32'h700 + 32'(8 * (k - 1))));
        check($sformatf("wrap%0d_pc1", k), 64'(bus.Decode_PC1), 64'(32'h704 + 32'(8 * (k - 1))));
      end
      tick(s);
    end
    step(idle);

    // Reset in the middle of an ID stall drops entries and clears counters.
    s = idle;
    s.rst = 1'b1;
    step(s);
    step(mk(2'b11, 32'h600, 32'h604, NOP, NOP, 2, 0, 0));
    repeat (5) step(mk(2'b00, 0, 0, 0, 0, 2, 0, 0));
    s = mk(2'b00, 0, 0, 0, 0, 2, 0, 0);
    s.rst = 1'b1;
    drive(s);
    #1;
`ifdef IFID_PERF_CNT_EN
    expPerf = 32'd5;
`else
    expPerf = 32'd0;
`endif
    check("stall_cnt_before_rst", 64'(perfIdStall), 64'(expPerf));
    check("count_before_rst", 64'(dbgCount), 64'd2);
    tick(s);
    drive(idle);
    #1;
    check("stall_cnt_after_rst", 64'(perfIdStall), 64'd0);
    check("flush_cnt_after_rst", 64'(perfFlush), 64'd0);
    check("count_after_rst", 64'(dbgCount), 64'd0);
    check("valid_after_rst", 64'(bus.Decode_Valid), 64'd0);
    check("ready_after_rst", 64'(bus.Fetch_Ready), 64'd1);
    tick(idle);

    // Random traffic against the model.
    for (int r = 0; r < 400; r++) begin
      s.rst   = ($urandom_range(0, 49) == 0);
      s.fv    = 2'($urandom_range(0, 3));
      s.pc0   = $urandom;
      s.pc1   = $urandom;
      s.inst0 = $urandom;
      s.inst1 = $urandom;
      s.stall = {3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0)};
      s.flush = {3'($urandom_range(0, 7)), ($urandom_range(0, 11) == 0)};
      s.issue = 4'($urandom_range(0, 15));
      step(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries; power of two, at least 4.
REQ-002 Parameter ADDR_WIDTH, default 32, PC width.
REQ-003 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port Fetch_Valid, input, 2: per-slot fetch valid; bit1 is honoured only when bit0=1.
REQ-006 Ports Fetch_PC0 and Fetch_PC1, input, ADDR_WIDTH: slot PCs.
REQ-007 Ports Fetch_Inst0 and Fetch_Inst1, input, 32: slot instruction words.
REQ-008 Port Fetch_Ready, output, 1: 1 when free entries >= 2.
REQ-009 Port Ctrl_Stall, input, 5: bit0 is the IF stall, bit1 is the ID stall; other bits are unused.
REQ-010 Port Flush, input, 4: bit0 is the IF-ID flush; other bits are unused.
REQ-011 Port issue_select, input, 4: bit0=1 means only slot0 issues this cycle.
REQ-012 Port Decode_Valid, output, 2: per-slot valid toward decode.
REQ-013 Ports Decode_PC0 and Decode_PC1, output, ADDR_WIDTH: head and head+1 PCs.
REQ-014 Ports Decode_Inst0 and Decode_Inst1, output, 32: head and head+1 instructions.
REQ-015 Ports Decode_16BitFlag_0 and Decode_16BitFlag_1, output, 1: slot is compressed, i.e. Inst[1:0]!=2'b11.

Function
REQ-016 The block SHALL be a circular FIFO with head pointer, tail pointer, and count in the range 0..DEPTH.
REQ-017 Pointers SHALL wrap modulo DEPTH.
REQ-018 Push is enabled when Fetch_Ready & !Ctrl_Stall[0] & Fetch_Valid[0] & !Flush[0].
  - Push count is 1 + Fetch_Valid[1].
  - Fetch_Valid=2'b10 pushes nothing.
REQ-019 Pop count SHALL be:
  - 0 if Ctrl_Stall[1] or Flush[0];
  - otherwise min(count, 1) if issue_select[0]=1;
  - otherwise min(count, 2).
REQ-020 Push and pop SHALL apply in the same cycle: count_next = count + push - pop.
  - When full, Fetch_Ready=0, so no overflow can occur.
REQ-021 When Flush[0]=1, the next state SHALL be head=tail=count=0, discarding all entries and same-cycle fetch data.
  - Flush has priority over stall, push, and pop.
REQ-022 Decode outputs SHALL be combinational reads of stored entries.
  - Fetch-to-decode latency is exactly 1 cycle.
  - There is no bypass from empty.
REQ-023 Decode_Valid SHALL be {count>=2, count>=1}, forced to 2'b00 while Flush[0]=1.
REQ-024 Invalid decode slots SHALL drive PC, Inst, and 16BitFlag as zero.
REQ-025 Fetch_Ready SHALL be a combinational function of the registered count only.
REQ-026 A stalled slot SHALL hold its PC and Inst stable until popped or flushed.

Reset
REQ-027 On rst=1 at a clock edge, head, tail, count, and storage valid state SHALL clear.
  - Decode_Valid=0, all decode data=0, Fetch_Ready=1.
REQ-028 Reset SHALL override flush, push, and pop in the same cycle.
REQ-029 Reset asserted mid-stall SHALL drop all held entries.

Configuration
REQ-030 Macro IFID_PERF_CNT_EN SHALL gate performance counters.
REQ-031 With IFID_PERF_CNT_EN defined, the block SHALL add two 32-bit outputs:
  - Perf_IdStallCnt increments each cycle Ctrl_Stall[1]=1 while Decode_Valid!=0.
  - Perf_FlushCnt increments each cycle Flush[0]=1.
  - Both clear on rst and wrap at 2^32.
REQ-032 Without the macro, both outputs SHALL exist and be tied to 32'h0, with no counter flops.

Structure
REQ-033 The shared define header SHALL hold:
  - ADDR_WIDTH and INST_WIDTH;
  - stall bit indices STALL_IF_BIT=0 and STALL_ID_BIT=1;
  - flush bit index FLUSH_IFID_BIT=0;
  - issue bit index ISSUE_SINGLE_BIT=0.
REQ-034 Storage SHALL be one sub-module, ifid_fifo_mem.
  - DEPTH x (ADDR_WIDTH+32) entries.
  - 2 write ports at tail and tail+1.
  - 2 asynchronous read ports at head and head+1.
  - No reset on the data array.

Verification
REQ-035 Dual push then dual issue:
  - Stimulus: after reset, push PC 0x100/0x104 with Inst 0x00000013/0x00000013.
  - Required response: next cycle Decode_Valid=2'b11; with no stall, count=0 one cycle later.
REQ-036 Single issue:
  - Stimulus: issue_select[0]=1 with 2 entries queued.
  - Required response: next cycle Decode_PC0=0x104 and Decode_Valid=2'b01.
REQ-037 Fill and wrap:
  - Stimulus: Ctrl_Stall[1]=1, push 2 pairs.
  - Required response: count=4, Fetch_Ready=0, third push ignored.
  - Then release the stall and push continuously for 8 cycles; PC order SHALL be preserved across pointer wrap.
REQ-038 Flush priority:
  - Stimulus: Flush[0]=1 concurrent with push and Ctrl_Stall[1]=1 at count=3.
  - Required response: Decode_Valid=0 that cycle; count=0 and Fetch_Ready=1 next cycle.
REQ-039 Compressed flag:
  - Stimulus: Inst0=0x00004501, Inst1=0x00000013.
  - Required response: Decode_16BitFlag_0=1 and Decode_16BitFlag_1=0.
REQ-040 Reset mid-stall with IFID_PERF_CNT_EN defined:
  - Stimulus: 5 stalled cycles, then rst.
  - Required response: Perf_IdStallCnt reads 5 before reset; it, Perf_FlushCnt, and count read 0 the cycle after rst.
